// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage behind the M-bit adder/subtractor.
// Captures result, carry and overflow, derives N/Z, and buffers entries in a
// 2-entry skid FIFO with a valid/ready handshake. Also counts accepted
// signed-overflow events in a saturating counter.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready is a pure register)
//   resultado, C, V     adder/subtractor result, carry-out, signed overflow
//   out_valid/out_ready downstream handshake
//   out_result, out_N, out_Z, out_C, out_V   head entry
//   ovf_clr             synchronous clear of the overflow counter
//   ovf_count           saturating count of accepted entries with V=1
module alu_result_stage #(
  parameter int unsigned M     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M-1:0]     resultado,
  input  logic             C,
  input  logic             V,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M-1:0]     out_result,
  output logic             out_N,
  output logic             out_Z,
  output logic             out_C,
  output logic             out_V,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_count
);

  // Entry layout: {result, N, Z, C, V}
  localparam int unsigned ENT_W = M + 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t             state_q, state_d;
  logic [ENT_W-1:0] head_q, head_d;
  logic [ENT_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q;
  logic             in_ready_q;

  logic             push;
  logic             pop;
  logic [ENT_W-1:0] in_entry;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // Flags are derived from the incoming result, never from the stored head.
  assign in_entry = {resultado, resultado[M-1], (resultado == '0), C, V};

  // Next-state: head register drives the outputs, skid holds the second entry.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;

    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = in_entry;
        end else if (push) begin
          skid_d  = in_entry;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can happen
        if (pop) begin
          head_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Clear wins over a same-cycle increment; saturate at all-ones.
    if (ovf_clr) begin
      cnt_d = '0;
    end else if (push && V && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, data and decoded handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      cnt_q       <= cnt_d;
      out_valid_q <= (state_d != EMPTY);
      in_ready_q  <= (state_d != FULL);
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = head_q[ENT_W-1:4];
  assign out_N      = head_q[3];
  assign out_Z      = head_q[2];
  assign out_C      = head_q[1];
  assign out_V      = head_q[0];
  assign ovf_count  = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage (M=4, CNT_W=2): a directed vector table with
// hand-derived expectations, then a random phase checked against a queue model.
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] resultado;
  logic       C;
  logic       V;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic       out_N, out_Z, out_C, out_V;
  logic       ovf_clr;
  logic [1:0] ovf_count;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.M(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .resultado(resultado), .C(C), .V(V),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_N(out_N), .out_Z(out_Z),
    .out_C(out_C), .out_V(out_V),
    .ovf_clr(ovf_clr), .ovf_count(ovf_count)
  );

  typedef struct {
    logic       rst, iv;
    logic [3:0] res;
    logic       c, v, ordy, clr;
    logic       eov, eir;
    logic [3:0] eres;
    logic       en, ez, ec, ev;
    logic [1:0] ecnt;
    logic       chkd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic iv, logic [3:0] res, logic c, logic v,
                              logic ordy, logic clr, logic eov, logic eir,
                              logic [3:0] eres, logic en, logic ez, logic ec,
                              logic ev, logic [1:0] ecnt, logic chkd);
    vec_t t;
    t.rst = r; t.iv = iv; t.res = res; t.c = c; t.v = v; t.ordy = ordy; t.clr = clr;
    t.eov = eov; t.eir = eir; t.eres = eres; t.en = en; t.ez = ez; t.ec = ec;
    t.ev = ev; t.ecnt = ecnt; t.chkd = chkd;
    return t;
  endfunction

  task automatic cmp(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [3:0] res,
                       input logic c, input logic v, input logic ordy, input logic clr);
    rst = r; in_valid = iv; resultado = res; C = c; V = v; out_ready = ordy; ovf_clr = clr;
  endtask

  // scoreboard model for the random phase
  logic [7:0] q[$];
  logic [1:0] mcnt;

  initial begin
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    //            rst iv res  c  v  ordy clr | ov ir eres N  Z  C  V  cnt chkd
    // reset held 2 cycles with in_valid=1
    tbl.push_back(mk(1, 1, 4'h5, 1, 1, 0, 0,  0, 1, 4'h0, 0, 0, 0, 0, 2'd0, 1));
    tbl.push_back(mk(1, 1, 4'h5, 1, 1, 0, 0,  0, 1, 4'h0, 0, 0, 0, 0, 2'd0, 1));
    // flags: zero with carry, then negative with overflow (push+pop at occ 1)
    tbl.push_back(mk(0, 1, 4'h0, 1, 0, 0, 0,  1, 1, 4'h0, 0, 1, 1, 0, 2'd0, 1));
    tbl.push_back(mk(0, 1, 4'h8, 0, 1, 1, 0,  1, 1, 4'h8, 1, 0, 0, 1, 2'd1, 1));
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 0,  0, 1, 4'h8, 1, 0, 0, 1, 2'd1, 1));
    // backpressure: 3, 5 stored, 7 refused, then drain 3 then 5
    tbl.push_back(mk(0, 1, 4'h3, 0, 0, 0, 0,  1, 1, 4'h3, 0, 0, 0, 0, 2'd1, 1));
    tbl.push_back(mk(0, 1, 4'h5, 0, 0, 0, 0,  1, 0, 4'h3, 0, 0, 0, 0, 2'd1, 1));
    tbl.push_back(mk(0, 1, 4'h7, 0, 1, 0, 0,  1, 0, 4'h3, 0, 0, 0, 0, 2'd1, 1));
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 0,  1, 1, 4'h5, 0, 0, 0, 0, 2'd1, 1));
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 0,  0, 1, 4'h5, 0, 0, 0, 0, 2'd1, 1));
    // simultaneous push/pop at occupancy 1
    tbl.push_back(mk(0, 1, 4'h2, 0, 0, 0, 0,  1, 1, 4'h2, 0, 0, 0, 0, 2'd1, 1));
    tbl.push_back(mk(0, 1, 4'h9, 0, 0, 1, 0,  1, 1, 4'h9, 1, 0, 0, 0, 2'd1, 1));
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 0,  0, 1, 4'h9, 1, 0, 0, 0, 2'd1, 1));
    // counter saturation: clear, five V pushes, then clear beats a V push
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 1,  0, 1, 4'h9, 1, 0, 0, 0, 2'd0, 1));
    tbl.push_back(mk(0, 1, 4'h1, 0, 1, 1, 0,  1, 1, 4'h1, 0, 0, 0, 1, 2'd1, 1));
    tbl.push_back(mk(0, 1, 4'h2, 0, 1, 1, 0,  1, 1, 4'h2, 0, 0, 0, 1, 2'd2, 1));
    tbl.push_back(mk(0, 1, 4'h3, 0, 1, 1, 0,  1, 1, 4'h3, 0, 0, 0, 1, 2'd3, 1));
    tbl.push_back(mk(0, 1, 4'h4, 0, 1, 1, 0,  1, 1, 4'h4, 0, 0, 0, 1, 2'd3, 1));
    tbl.push_back(mk(0, 1, 4'h5, 0, 1, 1, 0,  1, 1, 4'h5, 0, 0, 0, 1, 2'd3, 1));
    tbl.push_back(mk(0, 1, 4'h6, 0, 1, 1, 1,  1, 1, 4'h6, 0, 0, 0, 1, 2'd0, 1));
    // fill to 2, reset mid-stream, confirm nothing stale emerges
    tbl.push_back(mk(0, 1, 4'hA, 0, 0, 0, 0,  1, 0, 4'h6, 0, 0, 0, 1, 2'd0, 1));
    tbl.push_back(mk(1, 1, 4'hB, 1, 1, 1, 0,  0, 1, 4'h0, 0, 0, 0, 0, 2'd0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 0,  0, 1, 4'h0, 0, 0, 0, 0, 2'd0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 0,  0, 1, 4'h0, 0, 0, 0, 0, 2'd0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].res, tbl[i].c, tbl[i].v, tbl[i].ordy, tbl[i].clr);
      @(posedge clk);
      #1;
      n_vec++;
      cmp("out_valid", i, 32'(out_valid), 32'(tbl[i].eov));
      cmp("in_ready",  i, 32'(in_ready),  32'(tbl[i].eir));
      cmp("ovf_count", i, 32'(ovf_count), 32'(tbl[i].ecnt));
      if (tbl[i].chkd) begin
        cmp("out_result", i, 32'(out_result), 32'(tbl[i].eres));
        cmp("out_flags",  i, 32'({out_N, out_Z, out_C, out_V}),
            32'({tbl[i].en, tbl[i].ez, tbl[i].ec, tbl[i].ev}));
      end
    end

    // random phase against the queue model; the table ended empty with cnt 0
    q.delete();
    mcnt = 2'd0;
    for (int i = 0; i < 400; i++) begin
      logic       r, iv, c, v, ordy, clr, push_m, pop_m;
      logic [3:0] res;
      r    = ($urandom_range(0, 39) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      res  = 4'($urandom);
      c    = 1'($urandom);
      v    = 1'($urandom);
      clr  = ($urandom_range(0, 15) == 0);
      drive(r, iv, res, c, v, ordy, clr);
      push_m = iv && (q.size() < 2);
      pop_m  = ordy && (q.size() > 0);
      @(posedge clk);
      if (r) begin
        q.delete();
        mcnt = 2'd0;
      end else begin
        if (pop_m) void'(q.pop_front());
        if (push_m) q.push_back({res, res[3], (res == 4'h0), c, v});
        if (clr) mcnt = 2'd0;
        else if (push_m && v && (mcnt != 2'd3)) mcnt = mcnt + 2'd1;
      end
      #1;
      n_vec++;
      cmp("rnd_out_valid", 1000 + i, 32'(out_valid), 32'(q.size() != 0));
      cmp("rnd_in_ready",  1000 + i, 32'(in_ready),  32'(q.size() != 2));
      cmp("rnd_ovf_count", 1000 + i, 32'(ovf_count), 32'(mcnt));
      if (q.size() != 0)
        cmp("rnd_head", 1000 + i, 32'({out_result, out_N, out_Z, out_C, out_V}), 32'(q[0]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage placed directly downstream of the M-bit adder/subtractor. Each cycle it accepts the adder's result, carry and overflow, derives negative and zero flags, and holds the result and all four flags in a 2-entry skid FIFO behind a valid/ready handshake. It also keeps a saturating count of signed-overflow events. This decouples the combinational datapath from the consumer: register file write-back or flag register.

## Interface
- M, default 4: data width; must match the adder/subtractor's M; legal range 2..32
- CNT_W, default 8: width of the overflow event counter
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  upstream presents a result this cycle
- in_ready  output  1  stage can accept; low only when the FIFO holds 2 entries
- resultado  input  M  sum/difference from the adder/subtractor
- C  input  1  carry-out from the adder/subtractor
- V  input  1  signed overflow from the adder/subtractor
- out_valid  output  1  head entry is valid
- out_ready  input  1  consumer takes the head entry this cycle
- out_result  output  M  head entry result
- out_N  output  1  head entry negative flag
- out_Z  output  1  head entry zero flag
- out_C  output  1  head entry carry flag
- out_V  output  1  head entry overflow flag
- ovf_clr  input  1  synchronous clear of the overflow counter
- ovf_count  output  CNT_W  number of accepted entries with V=1, saturating

## Operation
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- On push, one entry is written to the tail: {resultado, N=resultado[M-1], Z=(resultado==0), C, V}.
- N and Z are computed from resultado combinationally before the write. No flag is computed from the head entry.
- The FIFO holds 2 entries. Occupancy is 0, 1 or 2.
- in_ready = (occupancy != 2). It is driven from a register only, with no combinational path from out_ready.
- out_valid = (occupancy != 0). The out_* outputs always reflect the head entry.
- Occupancy update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged; the head advances and the new entry is written behind it
  - neither: unchanged
- Push and pop together at occupancy 1: the new entry becomes the head on the next cycle.
- Push is impossible at occupancy 2 because in_ready is 0. in_valid is ignored while in_ready is 0.
- Pop at occupancy 0 is impossible because out_valid is 0. out_ready is ignored while out_valid is 0.
- When out_valid is 0, the out_* data is don't-care. It is held at its last value, never X after reset.
- Overflow counter:
  - On push with V=1, it increments by 1. At 2^CNT_W-1 it stays there (saturates, no wrap).
  - ovf_clr has priority over an increment in the same cycle; the result is 0.
- Upstream data (resultado, C, V) must be stable only in cycles where in_valid=1.

## Timing
- Reset (rst=1 at a rising edge) forces the following on the next cycle:
  - occupancy=0, out_valid=0, in_ready=1
  - out_result=0, out_N=0, out_Z=0, out_C=0, out_V=0
  - ovf_count=0
- Reset mid-operation discards every stored entry. Reset overrides push, pop and ovf_clr in the same cycle.
- Latency: an entry pushed at edge t appears on out_* with out_valid=1 after edge t, if the FIFO was empty. There is 1 cycle of latency and no bypass path.
- Throughput: 1 entry/cycle whenever out_ready is held high.
- Backpressure: with out_ready low, two entries are accepted. in_ready falls after the edge that stores the second entry.
- After out_ready returns high, in_ready rises one edge after the first pop.
- ovf_count reflects a push at edge t immediately after edge t.

## Test plan
- Reset: with M=4, assert rst for 2 cycles while in_valid=1 -> out_valid=0, in_ready=1, all out_* = 0, ovf_count=0.
- Flags: push resultado=4'b0000, C=1, V=0 -> next cycle out_Z=1, out_N=0, out_C=1. Then push 4'b1000, V=1 -> out_N=1, out_Z=0, out_V=1, ovf_count=1.
- Backpressure: out_ready=0, push 4'h3, 4'h5, then offer 4'h7 -> in_ready=0 on the third cycle and 4'h7 is not taken. Set out_ready=1 -> pops come out as 3 then 5, and in_ready=1 after the first pop.
- Simultaneous push and pop at occupancy 1: head=4'h2, push 4'h9 while popping -> occupancy stays 1, and next head=4'h9.
- Counter saturation: with CNT_W=2, push 5 entries with V=1 -> ovf_count reads 1,2,3,3,3. Then ovf_clr=1 together with a V=1 push -> ovf_count=0.
- Reset mid-stream: occupancy 2, assert rst for 1 cycle -> out_valid=0, in_ready=1, and no stale entries emerge afterwards.
